// File: rtl/counter_chain.sv
// rtl/counter_chain.sv - cascaded modulo-RADIX up/down counter with load, clear, wrap/saturate and sticky overflow
module counter_chain #(
    parameter int DIGITS   = 4,
    parameter int DIGIT_W  = 4,
    parameter int RADIX    = 10,
    parameter int SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ce,
    input  logic                        up,
    input  logic                        load,
    input  logic                        clr,
    input  logic [DIGITS*DIGIT_W-1:0]   di,
    output logic [DIGITS*DIGIT_W-1:0]   q,
    output logic                        ceo,
    output logic                        ovf
);

    localparam logic [DIGIT_W-1:0] MAX = DIGIT_W'(RADIX - 1);

    logic [DIGITS*DIGIT_W-1:0] q_q, q_d;
    logic                      ovf_q, ovf_d;
    logic [DIGITS:0]           cin;
    logic [DIGIT_W-1:0]        dig;
    logic                      terminal;
    logic                      ceo_c;

    always_comb begin
        cin    = '0;
        cin[0] = 1'b1;
        dig    = '0;
        // cin[k] is high when every digit below k sits at its end value for the current direction
        for (int k = 0; k < DIGITS; k++) begin
            dig        = q_q[k*DIGIT_W +: DIGIT_W];
            cin[k+1]   = cin[k] & (up ? (dig == MAX) : (dig == '0));
        end
        terminal = cin[DIGITS];
        ceo_c    = ce & ~load & ~clr & terminal;

        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (load) begin
            for (int k = 0; k < DIGITS; k++) begin
                dig = di[k*DIGIT_W +: DIGIT_W];
                q_d[k*DIGIT_W +: DIGIT_W] = (dig > MAX) ? MAX : dig;
            end
        end else if (ce && !((SATURATE != 0) && terminal)) begin
            for (int k = 0; k < DIGITS; k++) begin
                dig = q_q[k*DIGIT_W +: DIGIT_W];
                if (cin[k]) begin
                    if (up) begin
                        q_d[k*DIGIT_W +: DIGIT_W] = (dig == MAX) ? '0 : dig + DIGIT_W'(1);
                    end else begin
                        q_d[k*DIGIT_W +: DIGIT_W] = (dig == '0) ? MAX : dig - DIGIT_W'(1);
                    end
                end
            end
        end

        ovf_d = clr ? 1'b0 : (ovf_q | ceo_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = q_q;
    assign ovf = ovf_q;
    assign ceo = ceo_c;

endmodule

// File: doc/counter_chain.md
# counter_chain

Parametrised cascaded up/down counter: a chain of DIGITS digits, each counting modulo RADIX, with synchronous load, synchronous clear, wrap or saturate mode, terminal-count carry-out and a sticky overflow flag. It generalises the fixed-width binary and decimal counters in the counters top into one block. It is driven by the debounced button pulse or a ce1ms/ce1s strobe, and feeds the 16-bit seven-segment `dat` bus directly when DIGITS*DIGIT_W = 16.

## Interface
- DIGITS, 4, number of cascaded digits (1..8)
- DIGIT_W, 4, bits per digit (2..8)
- RADIX, 10, modulus of every digit (2..2^DIGIT_W); 10 gives BCD, 16 with DIGIT_W=4 gives binary
- SATURATE, 0, 0 = wrap at terminal count, 1 = hold at terminal count

- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ce  in  1  count enable, one-cycle strobe; one count step per cycle high
- up  in  1  direction: 1 = increment, 0 = decrement
- load  in  1  synchronous parallel load of di
- clr  in  1  synchronous clear of q and ovf
- di  in  DIGITS*DIGIT_W  load value, digit 0 in bits [DIGIT_W-1:0]
- q  out  DIGITS*DIGIT_W  counter value, digit 0 least significant
- ceo  out  1  terminal-count carry/borrow out, combinational
- ovf  out  1  sticky overflow/underflow flag

## Operation
- Priority per clock edge: rst (async) > clr > load > ce count > hold.
- rst low: q = 0, ovf = 0 immediately, independent of clk. Release is synchronous to the next edge; the first count is possible on the first edge with rst high.
- clr: q = 0, ovf = 0.
- load: each digit of di is loaded. A digit value >= RADIX is clamped to RADIX-1. ovf is unchanged. ce is ignored in a load cycle.
- Count up (ce=1, up=1):
  - digit 0 increments.
  - digit k increments when all lower digits are RADIX-1.
  - a digit at RADIX-1 that increments becomes 0.
- Count down (ce=1, up=0):
  - digit 0 decrements.
  - digit k decrements when all lower digits are 0.
  - a digit at 0 that decrements becomes RADIX-1.
- Terminal state: all digits RADIX-1 when up=1; all digits 0 when up=0.
- ceo = ce & !load & !clr & terminal state (evaluated with the current up). ceo may be chained into the ce of a further counter_chain.
- ovf is set on any edge where ceo=1, in both modes, and stays set until clr or rst.
- SATURATE=0: a count from the terminal state wraps: up gives all 0, down gives all RADIX-1.
- SATURATE=1: a count from the terminal state leaves q unchanged. ceo and ovf still behave as above.
- Digits are always within 0..RADIX-1; no illegal state is reachable.
- Changing up between strobes has no side effects. ceo follows up combinationally.
- Carry generation is a combinational prefix over the digits within one cycle (no ripple registers).

## Timing
- q is registered and updates on the edge that samples ce/load/clr. Latency is 1 cycle from input to q.
- ceo is combinational from ce, up, load, clr and the registered q: valid in the same cycle as ce, with no register stage.
- ovf is registered and becomes 1 one edge after the ceo cycle.
- Back-to-back ce (every cycle) is supported at full rate.
- Reset asserted mid-count: outputs go to 0 within the async path. No pending count survives reset.

## Test plan
Parameters are the defaults unless stated.
- Reset/clear: drive rst low mid-count -> q=0x0000 and ovf=0 asynchronously. Release, then ce x3 up -> q=0x0003.
- BCD carry: load 0x0999, then ce up -> q=0x1000, ceo=0. Load 0x1000, then ce down -> q=0x0999.
- Wrap and overflow: load 0x9999, up, ce -> ceo=1 in that cycle, q=0x0000 and ovf=1 next cycle. Then ce down -> ceo=1, q=0x9999. Then clr -> q=0, ovf=0.
- Load clamp and priority:
  - di=0x12F4 with load -> q=0x1294.
  - load, ce and clr together -> q=0 (clr wins).
  - load and ce together -> q=di, ceo=0.
- Saturate, SATURATE=1:
  - q=0x9999, up, ce x2 -> q stays 0x9999, ceo=1 each strobe, ovf=1.
  - q=0x0000, down, ce -> q stays 0x0000, ceo=1.
- Binary mode, RADIX=16, DIGITS=2: count up from 0x00 for 256 strobes -> q returns to 0x00 with exactly one ceo pulse, on the strobe at 0xFF. Compare every step against a reference modulo-256 model.
